// File: rtl/alu_io_pkg.sv
// Constants and state encoding shared by the ALU operand loader, the result
// register and the ALU core.
package alu_io_pkg;

    localparam int WORD_W = 32;
    localparam int OUT_W  = 128;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage : alu_io_pkg

// File: rtl/operand_loader.sv
// Assembles a {A, B} operand bundle from a narrow word stream (MSW first) and
// holds it for the ALU datapath until the datapath accepts it.
module operand_loader
    import alu_io_pkg::*;
#(
    parameter int WORD_W = alu_io_pkg::WORD_W,
    parameter int OUT_W  = alu_io_pkg::OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);

    localparam int WORDS = OUT_W / WORD_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORDS - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               err_reg;
    logic [WORD_W-1:0]  slot_reg [WORDS];

    logic in_xfer;
    logic short_last;

    assign in_ready   = (state_reg == LOAD) && !rst;
    assign out_valid  = (state_reg == FULL);
    assign err        = err_reg;
    assign in_xfer    = in_valid && in_ready;
    // A last word arriving before the final slot ends the bundle early.
    assign short_last = in_xfer && in_last && (idx_reg != IDX_MAX);

    // Slot gi holds word index gi; word 0 lands in the most significant slot.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg[gi] <= '0;
                end else if (in_xfer) begin
                    if (idx_reg == IDX_W'(gi)) begin
                        slot_reg[gi] <= in;
                    end else if (short_last && (IDX_W'(gi) > idx_reg)) begin
                        slot_reg[gi] <= '0;
                    end
                end
            end

            assign out[OUT_W-1-gi*WORD_W -: WORD_W] = slot_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (in_xfer) begin
                        if (idx_reg == IDX_MAX) begin
                            state_reg <= FULL;
                            if (!in_last) begin
                                err_reg <= 1'b1;
                            end
                        end else if (in_last) begin
                            state_reg <= FULL;
                            err_reg   <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_reg <= LOAD;
                        idx_reg   <= '0;
                    end
                end
                default: begin
                    state_reg <= LOAD;
                    idx_reg   <= '0;
                end
            endcase
        end
    end

endmodule : operand_loader

// File: doc/operand_loader.md
# operand_loader

Input-side counterpart of the ALU result register: collects a 128-bit operand bundle, {A[63:0], B[63:0]}, from a narrow 32-bit word stream using a valid/ready handshake. It presents the complete bundle to the 64-bit ALU datapath and holds it until the datapath accepts it. It sits between the operand source (host/testbench bus) and the ALU core.

## Interface
Parameters:
- WORD_W, 32, width of one input word
- OUT_W, 128, width of the assembled bundle; must be an integer multiple of WORD_W
- WORDS, OUT_W/WORD_W (4), derived localparam, words per bundle

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- rst  input  1  reset; synchronous, active-high
- in  input  WORD_W  input data word
- in_valid  input  1  word on `in` is valid
- in_last  input  1  word on `in` is the final word of the bundle
- in_ready  output  1  loader can accept a word
- out  output  OUT_W  assembled bundle; A = out[127:64], B = out[63:0]
- out_valid  output  1  `out` holds a complete bundle
- out_ready  input  1  ALU consumes the bundle
- err  output  1  sticky framing error flag

## Operation
- States:
  - LOAD: accepting words.
  - FULL: bundle complete, waiting for the consumer.
- Input transfer: in_valid && in_ready at posedge clk.
- Output transfer: out_valid && out_ready at posedge clk.
- in_ready = (state == LOAD) && !rst. out_valid = (state == FULL).
- Word order is MSW first:
  - word index k (0..WORDS-1) is written to out[OUT_W-1-k*WORD_W -: WORD_W]
  - word 0 goes to A[63:32]; word 3 goes to B[31:0].
- Index counter idx, width $clog2(WORDS), runs 0..WORDS-1. It resets to 0 on entry to LOAD.
- LOAD transitions:
  - Transfer with idx < WORDS-1 and !in_last: store the word, idx++.
  - Transfer with idx < WORDS-1 and in_last (short bundle): store the word, zero-fill all remaining lower slots, set err, go to FULL.
  - Transfer with idx == WORDS-1: store the word, go to FULL. If in_last is 0, set err; the bundle is still delivered.
- FULL transitions:
  - On output transfer, go to LOAD with idx = 0.
  - `out` keeps its value after the transfer until overwritten by the next word.
  - No input transfer can occur in FULL (in_ready = 0).
- Words with in_valid = 0 are ignored. Holes are allowed; idx advances only on transfer.
- At the start of each bundle, `out` slots not yet written keep their previous contents. Only the short-bundle path zero-fills.
- err is sticky and is cleared only by rst.

## Timing
- Reset (rst high at posedge clk):
  - out = 0, out_valid = 0, err = 0, state = LOAD, idx = 0.
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after rst deasserts.
- Latency: out_valid rises in the cycle after the posedge that accepts the final word. A full bundle takes at least WORDS cycles to load plus 1 cycle to present.
- Throughput: at most one bundle per WORDS+1 cycles. The FULL cycle with out_ready = 1 is the bubble.
- out_ready held high in FULL: the transfer completes on the first FULL edge, and in_ready rises on the next cycle.
- out_ready low: out and out_valid hold indefinitely and stay stable.
- Reset mid-bundle or in FULL: the partial or pending bundle is discarded with no transfer, and the block returns to reset values.
- in_last together with in_valid = 0: no effect.

## Structure
- Shared package alu_io_pkg holds:
  - WORD_W, OUT_W constants (shared with the result register and the ALU core)
  - state enum {LOAD, FULL}
- Single module. No sub-module needed; the index counter is inline.

## Test plan
- Reset, then 4 words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with in_last on word 3 and out_ready = 1 -> out = 0x11111111_22222222_33333333_44444444 one cycle after the 4th accept; out_valid high for exactly 1 cycle; err = 0.
- Same bundle with out_ready held low 5 cycles -> out and out_valid stable for 5 cycles, in_ready = 0 throughout; transfer on the 6th edge, in_ready = 1 the next cycle.
- Short bundle: words 0xAAAA0000, 0xBBBB0000 with in_last on the 2nd -> out = 0xAAAA0000_BBBB0000_00000000_00000000, err = 1, err stays 1 across later bundles until rst.
- Missing in_last on word 3 -> bundle delivered normally, err = 1.
- in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 words captured in order, out_valid rises after the 4th accept.
- rst asserted after 2 words accepted, then a clean 4-word bundle -> out = 0 and out_valid = 0 during reset; the new bundle is assembled from idx 0 with no leftover words.
